// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: word constants and FSM encodings.
package inst_fetch_pkg;

  localparam int unsigned InstWidth = 32;
  localparam logic [InstWidth-1:0] ZeroWord = '0;

  typedef enum logic [1:0] {
    S_LOOKUP = 2'd0,
    S_MISS   = 2'd1,
    S_DRAIN  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_icache_dm.sv
// Direct-mapped one-word-per-line instruction cache: combinational lookup, synchronous fill.
// Valid bits clear on reset; tag and data arrays are plain storage without reset.
module icache_dm
  import inst_fetch_pkg::*;
#(
  parameter int unsigned LINES      = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:2] rd_addr_i,
  output logic                  hit_o,
  output logic [InstWidth-1:0]  rd_data_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:2] wr_addr_i,
  input  logic [InstWidth-1:0]  wr_data_i
);

  localparam int unsigned IDX = $clog2(LINES);
  localparam int unsigned TAG = ADDR_WIDTH - IDX - 2;

  logic [LINES-1:0]     valid_q;
  logic [TAG-1:0]       tag_q  [LINES];
  logic [InstWidth-1:0] data_q [LINES];

  logic [IDX-1:0] rd_idx, wr_idx;
  logic [TAG-1:0] rd_tag, wr_tag;

  assign rd_idx = rd_addr_i[IDX+1:2];
  assign rd_tag = rd_addr_i[ADDR_WIDTH-1:IDX+2];
  assign wr_idx = wr_addr_i[IDX+1:2];
  assign wr_tag = wr_addr_i[ADDR_WIDTH-1:IDX+2];

  assign hit_o     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// IF stage: cache lookup of the fetch PC, single-outstanding memory refill, flush and stall handling.
// Build option ICACHE_EN instantiates the cache; without it every lookup misses and nothing is stored.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned ICACHE_LINES = 64,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  input  logic                  flush,
  input  logic                  stall_in,
  output logic                  stall_out,
  output logic                  if_valid,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic [InstWidth-1:0]  if_inst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [InstWidth-1:0]  mem_rdata,
  input  logic                  mem_done
);

  fetch_state_e          state_q;
  logic                  if_valid_q;
  logic [ADDR_WIDTH-1:0] if_pc_q;
  logic [InstWidth-1:0]  if_inst_q;
  logic                  mem_req_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [ADDR_WIDTH-1:0] miss_pc_q;

  logic                  cache_hit;
  logic [InstWidth-1:0]  cache_data;
  logic                  lookup_miss;

`ifdef ICACHE_EN
  logic fill_en;

  // Both a normal refill and a drained (flushed) refill land in the cache.
  assign fill_en = rdy_in && !rst_in && mem_done && (state_q != S_LOOKUP);

  icache_dm #(
    .LINES      (ICACHE_LINES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_icache (
    .clk_i     (clk_in),
    .rst_i     (rst_in),
    .rd_addr_i (pc_in[ADDR_WIDTH-1:2]),
    .hit_o     (cache_hit),
    .rd_data_o (cache_data),
    .wr_en_i   (fill_en),
    .wr_addr_i (miss_pc_q[ADDR_WIDTH-1:2]),
    .wr_data_i (mem_rdata)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = ZeroWord;
`endif

  assign lookup_miss = (state_q == S_LOOKUP) && !cache_hit;
  assign stall_out   = (state_q != S_LOOKUP) || lookup_miss || stall_in;

  assign if_valid = if_valid_q;
  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_LOOKUP;
      if_valid_q <= 1'b0;
      if_pc_q    <= '0;
      if_inst_q  <= ZeroWord;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      miss_pc_q  <= '0;
    end else if (rdy_in) begin
      case (state_q)
        S_LOOKUP: begin
          if (flush) begin
            if_valid_q <= 1'b0;
          end else if (!stall_in) begin
            if (cache_hit) begin
              if_valid_q <= 1'b1;
              if_pc_q    <= pc_in;
              if_inst_q  <= cache_data;
            end else begin
              if_valid_q <= 1'b0;
              mem_req_q  <= 1'b1;
              mem_addr_q <= {pc_in[ADDR_WIDTH-1:2], 2'b00};
              miss_pc_q  <= pc_in;
              state_q    <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (mem_done) begin
            state_q   <= S_LOOKUP;
            mem_req_q <= 1'b0;
            if (flush) begin
              if_valid_q <= 1'b0;
            end else if (!stall_in) begin
              if_valid_q <= 1'b1;
              if_pc_q    <= miss_pc_q;
              if_inst_q  <= mem_rdata;
            end
          end else if (flush) begin
            // Request stays up; its data is dropped when it arrives.
            if_valid_q <= 1'b0;
            state_q    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (mem_done) begin
            state_q   <= S_LOOKUP;
            mem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_LOOKUP;
        end
      endcase
    end
  end

endmodule
